// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: holds all downstream resets, then releases them one stage at a time,
// and re-enters reset on a software request or watchdog expiry while recording the cause.
module rst_seq_ctrl #(
  parameter int unsigned HOLD_CYC  = 16,
  parameter int unsigned STAGE_GAP = 4,
  parameter int unsigned NSTAGE    = 3
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              soft_rst_req,
  input  logic              wdt_expire,
  output logic [NSTAGE-1:0] stage_rst_n,
  output logic              rst_busy,
  output logic [1:0]        rst_cause
);

  localparam int unsigned CntMax = (HOLD_CYC > STAGE_GAP) ? HOLD_CYC : STAGE_GAP;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  // idx counts one past the last stage once the sequence completes.
  localparam int unsigned IdxW   = (NSTAGE > 0) ? $clog2(NSTAGE + 1) : 1;

  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYC - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(STAGE_GAP - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NSTAGE - 1);

  localparam logic [1:0] CausePor  = 2'b01;
  localparam logic [1:0] CauseSoft = 2'b10;
  localparam logic [1:0] CauseWdt  = 2'b11;

  typedef enum logic [1:0] {
    StAssert,
    StRelease,
    StRun
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NSTAGE-1:0] stage_q, stage_d;
  logic              busy_q, busy_d;
  logic [1:0]        cause_q, cause_d;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      busy_q  <= 1'b1;
      cause_q <= CausePor;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    busy_d  = busy_q;
    cause_d = cause_q;

    if (soft_rst_req || wdt_expire) begin
      // A request in any state, including ASSERT, restarts the full hold.
      state_d = StAssert;
      cnt_d   = '0;
      idx_d   = '0;
      stage_d = '0;
      busy_d  = 1'b1;
      cause_d = wdt_expire ? CauseWdt : CauseSoft;
    end else begin
      case (state_q)
        StAssert: begin
          if (cnt_q == HoldLast) begin
            stage_d[0] = 1'b1;
            cnt_d      = '0;
            idx_d      = IdxW'(1);
            if (NSTAGE == 1) begin
              state_d = StRun;
              busy_d  = 1'b0;
            end else begin
              state_d = StRelease;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StRelease: begin
          if (cnt_q == GapLast) begin
            for (int unsigned i = 0; i < NSTAGE; i++) begin
              if (idx_q == IdxW'(i)) stage_d[i] = 1'b1;
            end
            idx_d = idx_q + IdxW'(1);
            cnt_d = '0;
            if (idx_q == IdxLast) begin
              state_d = StRun;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StRun: begin
        end
        default: state_d = StAssert;
      endcase
    end
  end

  assign stage_rst_n = stage_q;
  assign rst_busy    = busy_q;
  assign rst_cause   = cause_q;

endmodule
